branch_resolve_bht: RTL and testbench

Parametrised branch/jump resolution unit with a dynamic predictor. It evaluates the branch condition in the execute stage from the ALU condition flags and the instruction's condition field, and compares the outcome against the prediction made at fetch. On a mismatch it issues a redirect and a pipeline flush. It also owns a table of 2-bit saturating counters, looked up by fetch and trained by each resolved branch.

---
 rtl/branch_resolve_bht.sv | 93 +++++++++
 tb/tb_branch_resolve_bht.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// Branch/jump resolution with shadow squash and an optional 2-bit counter BHT.
// Optional predictor storage is enabled by defining BRANCH_PREDICT_EN.
module branch_resolve_bht #(
  parameter int PC_WIDTH  = 16,
  parameter int BHT_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] fetch_pc,
  output logic                pred_taken,
  input  logic                res_valid,
  input  logic                res_is_jump,
  input  logic [PC_WIDTH-1:0] res_pc,
  input  logic [15:0]         res_instr,
  input  logic                res_pred,
  input  logic [5:0]          flags,
  output logic                redirect_target,
  output logic                redirect_fall,
  output logic                flush
);

  localparam int IDX = $clog2(BHT_DEPTH);

  logic shadow;
  logic cond_true;
  logic act;
  logic ev;
  logic pred_eff;

  function automatic logic cond_eval(input logic [2:0] code, input logic [5:0] f);
    logic r;
    case (code)
      3'b000:  r = f[0];
      3'b001:  r = f[1];
      3'b010:  r = f[2];
      3'b011:  r = f[3];
      3'b100:  r = f[4];
      3'b101:  r = f[5];
      3'b110:  r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign cond_true = cond_eval(res_instr[2:0], flags);
  assign act       = res_is_jump | cond_true;
  // Gating with rst keeps every redirect quiet while reset is held.
  assign ev        = res_valid & ~shadow & ~rst;

  assign redirect_target = ev & act & ~pred_eff;
  assign redirect_fall   = ev & ~act & pred_eff;
  assign flush           = redirect_target | redirect_fall;

  // The instruction entering execute right after a flush is wrong-path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= 1'b0;
    else     shadow <= flush;
  end

`ifdef BRANCH_PREDICT_EN
  logic [1:0] bht [BHT_DEPTH];
  logic       unused_bits;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (ev && !res_is_jump) begin
      bht[res_pc[IDX-1:0]] <= act ? sat_inc(bht[res_pc[IDX-1:0]])
                                  : sat_dec(bht[res_pc[IDX-1:0]]);
    end
  end

  // Lookup sees the pre-update counter on a same-index train.
  assign pred_taken  = bht[fetch_pc[IDX-1:0]][1];
  assign pred_eff    = res_pred;
  assign unused_bits = ^{fetch_pc[PC_WIDTH-1:IDX], res_pc[PC_WIDTH-1:IDX], res_instr[15:3]};
`else
  logic unused_bits;

  assign pred_taken  = 1'b0;
  assign pred_eff    = 1'b0;
  assign unused_bits = ^{fetch_pc, res_pc, res_pred, res_instr[15:3]};
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed bench for branch_resolve_bht: per-cycle model comparison plus literal checks.
module tb_branch_resolve_bht;

`ifdef BRANCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fetch_pc = '0;
  logic        pred_taken;
  logic        res_valid = 1'b0;
  logic        res_is_jump = 1'b0;
  logic [15:0] res_pc = '0;
  logic [15:0] res_instr = '0;
  logic        res_pred = 1'b0;
  logic [5:0]  flags = '0;
  logic        redirect_target, redirect_fall, flush;

  int total = 0;
  int bad   = 0;

  branch_resolve_bht #(.PC_WIDTH(16), .BHT_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_is_jump(res_is_jump), .res_pc(res_pc),
    .res_instr(res_instr), .res_pred(res_pred), .flags(flags),
    .redirect_target(redirect_target), .redirect_fall(redirect_fall), .flush(flush)
  );

  always #5 clk = ~clk;

  // Model state: counters as plain integers 0..3, shadow as a flag.
  int m_cnt [16];
  bit m_shadow;
  bit e_pt, e_rt, e_rf, e_fl, e_act, e_ev;

  function automatic bit cond_holds(input logic [2:0] code, input logic [5:0] f);
    if (code == 3'd7) return 1'b0;
    if (code == 3'd6) return 1'b1;
    return f[code];
  endfunction

  always_comb begin
    e_pt  = PRED && (m_cnt[fetch_pc[3:0]] >= 2);
    e_act = res_is_jump || cond_holds(res_instr[2:0], flags);
    e_ev  = res_valid && !m_shadow && !rst;
    e_rt  = e_ev && e_act && !(PRED && res_pred);
    e_rf  = e_ev && !e_act && (PRED && res_pred);
    e_fl  = e_rt || e_rf;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 1;
      m_shadow = 1'b0;
    end else begin
      if (PRED && e_ev && !res_is_jump) begin
        if (e_act) m_cnt[res_pc[3:0]] = (m_cnt[res_pc[3:0]] == 3) ? 3 : m_cnt[res_pc[3:0]] + 1;
        else       m_cnt[res_pc[3:0]] = (m_cnt[res_pc[3:0]] == 0) ? 0 : m_cnt[res_pc[3:0]] - 1;
      end
      m_shadow = e_fl;
    end
  end

  task automatic check(input string name, input logic act_v, input logic exp_v);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act_v, exp_v);
    end
  endtask

  always @(negedge clk) begin
    check("model_pred_taken", pred_taken, e_pt);
    check("model_redirect_target", redirect_target, e_rt);
    check("model_redirect_fall", redirect_fall, e_rf);
    check("model_flush", flush, e_fl);
  end

  // Applies one cycle of inputs just after a rising edge and returns at the falling edge.
  task automatic step(input logic v, input logic j, input logic [15:0] pc,
                      input logic [2:0] code, input logic p, input logic [5:0] f,
                      input logic [15:0] fpc);
    @(posedge clk);
    #1;
    res_valid = v; res_is_jump = j; res_pc = pc; res_instr = {13'h0abc, code};
    res_pred = p; flags = f; fetch_pc = fpc;
    @(negedge clk);
  endtask

  task automatic idle(input logic [15:0] fpc);
    step(1'b0, 1'b0, 16'd0, 3'd7, 1'b0, 6'd0, fpc);
  endtask

  initial begin
    // Resolve presented while reset is held must stay silent.
    #1;
    res_valid = 1'b1; res_instr = 16'h0004; flags = 6'b010000;
    @(negedge clk);
    check("reset_flush", flush, 1'b0);
    check("reset_rt", redirect_target, 1'b0);
    check("reset_pt", pred_taken, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0; res_valid = 1'b0;

    for (int i = 0; i < 16; i++) begin
      idle(16'(i));
      check("cold_pt", pred_taken, 1'b0);
    end

    // EQ taken, predicted not-taken; repeat shows the shadow; third re-arms.
    step(1'b1, 1'b0, 16'd7, 3'b100, 1'b0, 6'b010000, 16'd0);
    check("eq_rt", redirect_target, 1'b1);
    check("eq_flush", flush, 1'b1);
    step(1'b1, 1'b0, 16'd7, 3'b100, 1'b0, 6'b010000, 16'd0);
    check("shadow_flush", flush, 1'b0);
    step(1'b1, 1'b0, 16'd7, 3'b100, 1'b0, 6'b010000, 16'd0);
    check("rearm_flush", flush, 1'b1);
    idle(16'd3);

    // Train index 3: taken x3, not-taken x2.
    check("t3_init", pred_taken, 1'b0);
    step(1'b1, 1'b0, 16'd3, 3'b110, 1'b1, 6'd0, 16'd3);
    idle(16'd3);
    check("t3_after1", pred_taken, PRED);
    step(1'b1, 1'b0, 16'd3, 3'b110, 1'b1, 6'd0, 16'd3);
    idle(16'd3);
    check("t3_after2", pred_taken, PRED);
    step(1'b1, 1'b0, 16'd3, 3'b110, 1'b1, 6'd0, 16'd3);
    idle(16'd3);
    check("t3_sat", pred_taken, PRED);
    step(1'b1, 1'b0, 16'd3, 3'b111, 1'b1, 6'd0, 16'd3);
    idle(16'd3);
    check("t3_nt1", pred_taken, PRED);
    step(1'b1, 1'b0, 16'd3, 3'b111, 1'b1, 6'd0, 16'd3);
    idle(16'd3);
    check("t3_nt2", pred_taken, 1'b0);

    // Never/always codes against a taken prediction.
    step(1'b1, 1'b0, 16'd9, 3'b111, 1'b1, 6'b111111, 16'd0);
    check("never_rf", redirect_fall, PRED);
    idle(16'd0);
    step(1'b1, 1'b0, 16'd10, 3'b110, 1'b1, 6'd0, 16'd0);
    check("always_flush", flush, !PRED);
    idle(16'd5);

    // Jump at index 5 redirects and leaves the counter alone.
    step(1'b1, 1'b1, 16'd5, 3'b111, 1'b0, 6'd0, 16'd5);
    check("jump_rt", redirect_target, 1'b1);
    idle(16'd5);
    idle(16'd5);
    check("jump_no_train", pred_taken, 1'b0);

    // Same-cycle lookup and train of index 2.
    step(1'b1, 1'b0, 16'd2, 3'b110, 1'b1, 6'd0, 16'd2);
    check("bypass_old", pred_taken, 1'b0);
    idle(16'd2);
    check("bypass_new", pred_taken, PRED);

    // Reset lands mid-train of index 4; both 2 and 4 return to 01.
    step(1'b1, 1'b0, 16'd4, 3'b110, 1'b1, 6'd0, 16'd2);
    rst = 1'b1;
    #1;
    check("midrst_pt2", pred_taken, 1'b0);
    check("midrst_flush", flush, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(16'd4);
    check("midrst_pt4", pred_taken, 1'b0);
    step(1'b1, 1'b0, 16'd4, 3'b110, 1'b1, 6'd0, 16'd4);
    idle(16'd4);
    check("midrst_from01", pred_taken, PRED);

    // Condition decode sweep over codes, flag patterns and predictions.
    for (int c = 0; c < 8; c++) begin
      for (int fp = 0; fp < 3; fp++) begin
        for (int p = 0; p < 2; p++) begin
          logic [5:0] f;
          f = (fp == 0) ? 6'd0 : (fp == 1) ? 6'b111111 : ((c < 6) ? 6'(1 << c) : 6'b101010);
          step(1'b1, 1'b0, 16'(c + 8), 3'(c), 1'(p), f, 16'(c + 8));
          idle(16'(c + 8));
        end
      end
    end

    // One more literal pin on decode: GE true while only GE set, predicted taken.
    step(1'b1, 1'b0, 16'd1, 3'b011, 1'b1, 6'b001000, 16'd0);
    check("ge_taken_flush", flush, !PRED);
    idle(16'd0);
    step(1'b1, 1'b0, 16'd1, 3'b000, 1'b0, 6'b111110, 16'd0);
    check("lt_false_flush", flush, 1'b0);
    idle(16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
